// File: rtl/keypad_scan_debounce_pkg.sv
// Shared encodings for the keypad scanner and its debounce FSM.
// Matrix dimensions, state and scan-result types, and a column-count helper.
package keypad_scan_debounce_pkg;

    localparam int N_ROWS = 4;
    localparam int N_COLS = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAND    = 2'd1,
        ST_PRESSED = 2'd2,
        ST_REL     = 2'd3
    } kp_state_t;

    typedef enum logic [1:0] {
        SCAN_NONE   = 2'd0,
        SCAN_SINGLE = 2'd1,
        SCAN_MULTI  = 2'd2
    } scan_result_t;

    // Number of low (closed) columns, saturated at 2: only 0 / 1 / many matters.
    function automatic logic [1:0] low_count_sat(input logic [N_COLS-1:0] cols);
        logic [1:0] n;
        n = 2'd0;
        for (int i = 0; i < N_COLS; i++) begin
            if (!cols[i] && n != 2'd2) begin
                n = n + 2'd1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/keypad_row_scanner.sv
// Drives one keypad row low at a time, synchronizes the column returns and
// classifies each full-matrix scan as none / single key / multiple keys.
module keypad_row_scanner
    import keypad_scan_debounce_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1200
) (
    input  logic               hwclk,
    input  logic               rst_n,
    output logic [N_ROWS-1:0]  keypad_r,
    input  logic [N_COLS-1:0]  keypad_c,
    output logic               scan_done,
    output scan_result_t       scan_result,
    output logic [3:0]         scan_code
);

    localparam int DW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SETTLE_CYCLES - 1);

    logic              run_reg;
    logic [1:0]        row_reg;
    logic [DW-1:0]     dwell_reg;
    logic [N_COLS-1:0] c_meta_reg;
    logic [N_COLS-1:0] c_sync_reg;
    logic [1:0]        acc_cnt_reg;
    logic [3:0]        acc_code_reg;
    logic              scan_done_reg;
    scan_result_t      scan_result_reg;
    logic [3:0]        scan_code_reg;

    logic              sample;
    logic [1:0]        row_cnt;
    logic [1:0]        col_idx;
    logic [2:0]        sum_raw;
    logic [1:0]        total_next;
    logic [3:0]        code_next;

    // Rows are released (all high) until the first cycle after reset.
    generate
        for (genvar gi = 0; gi < N_ROWS; gi++) begin : g_row_drive
            assign keypad_r[gi] = ~(run_reg && (row_reg == 2'(gi)));
        end
    endgenerate

    always_comb begin
        sample  = run_reg && (dwell_reg == DWELL_LAST);
        row_cnt = low_count_sat(c_sync_reg);
        col_idx = 2'd0;
        for (int i = N_COLS - 1; i >= 0; i--) begin
            if (!c_sync_reg[i]) begin
                col_idx = 2'(i);
            end
        end
        sum_raw    = {1'b0, acc_cnt_reg} + {1'b0, row_cnt};
        total_next = (sum_raw >= 3'd2) ? 2'd2 : sum_raw[1:0];
        // The single key's code comes from whichever row contributed it.
        code_next  = (acc_cnt_reg == 2'd0 && row_cnt == 2'd1) ? {row_reg, col_idx} : acc_code_reg;
    end

    always_ff @(posedge hwclk) begin
        if (!rst_n) begin
            run_reg         <= 1'b0;
            row_reg         <= 2'd0;
            dwell_reg       <= '0;
            c_meta_reg      <= '1;
            c_sync_reg      <= '1;
            acc_cnt_reg     <= 2'd0;
            acc_code_reg    <= 4'd0;
            scan_done_reg   <= 1'b0;
            scan_result_reg <= SCAN_NONE;
            scan_code_reg   <= 4'd0;
        end else begin
            run_reg       <= 1'b1;
            scan_done_reg <= 1'b0;
            c_meta_reg    <= keypad_c;
            c_sync_reg    <= c_meta_reg;
            if (sample) begin
                dwell_reg <= '0;
                row_reg   <= row_reg + 2'd1;
                if (row_reg == 2'(N_ROWS - 1)) begin
                    scan_done_reg   <= 1'b1;
                    scan_result_reg <= (total_next == 2'd0) ? SCAN_NONE :
                                       (total_next == 2'd1) ? SCAN_SINGLE : SCAN_MULTI;
                    scan_code_reg   <= code_next;
                    acc_cnt_reg     <= 2'd0;
                    acc_code_reg    <= 4'd0;
                end else begin
                    acc_cnt_reg  <= total_next;
                    acc_code_reg <= code_next;
                end
            end else if (run_reg) begin
                dwell_reg <= dwell_reg + DW'(1);
            end
        end
    end

    assign scan_done   = scan_done_reg;
    assign scan_result = scan_result_reg;
    assign scan_code   = scan_code_reg;

endmodule

// File: rtl/keypad_scan_debounce.sv
// 4x4 keypad front end: row scanner plus a scan-rate debounce FSM that emits
// registered one-cycle press/release pulses and the accepted key code.
module keypad_scan_debounce
    import keypad_scan_debounce_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 1200,
    parameter int DEBOUNCE_SCANS = 20
) (
    input  logic               hwclk,
    input  logic               rst_n,
    output logic [N_ROWS-1:0]  keypad_r,
    input  logic [N_COLS-1:0]  keypad_c,
    output logic [3:0]         key_code,
    output logic               key_press,
    output logic               key_release,
    output logic               key_down
);

    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] CNT_LIMIT = CW'(DEBOUNCE_SCANS);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    logic         scan_done;
    scan_result_t scan_result;
    logic [3:0]   scan_code;

    kp_state_t    state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next, cnt_inc;
    logic [3:0]   cand_reg, cand_next;
    logic [3:0]   key_code_reg, key_code_next;
    logic         press_reg, press_next;
    logic         release_reg, release_next;

    keypad_row_scanner #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_scanner (
        .hwclk      (hwclk),
        .rst_n      (rst_n),
        .keypad_r   (keypad_r),
        .keypad_c   (keypad_c),
        .scan_done  (scan_done),
        .scan_result(scan_result),
        .scan_code  (scan_code)
    );

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        cand_next     = cand_reg;
        key_code_next = key_code_reg;
        press_next    = 1'b0;
        release_next  = 1'b0;
        cnt_inc       = (cnt_reg >= CNT_LIMIT) ? CNT_LIMIT : cnt_reg + CNT_ONE;
        if (scan_done) begin
            unique case (state_reg)
                ST_IDLE: begin
                    if (scan_result == SCAN_SINGLE) begin
                        cand_next = scan_code;
                        cnt_next  = CNT_ONE;
                        // A limit of one accepts on the very first qualifying scan.
                        if (CNT_ONE >= CNT_LIMIT) begin
                            state_next    = ST_PRESSED;
                            key_code_next = scan_code;
                            press_next    = 1'b1;
                        end else begin
                            state_next = ST_CAND;
                        end
                    end
                end
                ST_CAND: begin
                    if (scan_result == SCAN_SINGLE && scan_code == cand_reg) begin
                        cnt_next = cnt_inc;
                        if (cnt_inc >= CNT_LIMIT) begin
                            state_next    = ST_PRESSED;
                            key_code_next = cand_reg;
                            press_next    = 1'b1;
                        end
                    end else if (scan_result == SCAN_SINGLE) begin
                        cand_next = scan_code;
                        cnt_next  = CNT_ONE;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
                ST_PRESSED: begin
                    if (scan_result == SCAN_NONE) begin
                        cnt_next = CNT_ONE;
                        if (CNT_ONE >= CNT_LIMIT) begin
                            state_next   = ST_IDLE;
                            release_next = 1'b1;
                        end else begin
                            state_next = ST_REL;
                        end
                    end
                end
                ST_REL: begin
                    if (scan_result == SCAN_NONE) begin
                        cnt_next = cnt_inc;
                        if (cnt_inc >= CNT_LIMIT) begin
                            state_next   = ST_IDLE;
                            release_next = 1'b1;
                        end
                    end else begin
                        state_next = ST_PRESSED;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge hwclk) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            cand_reg     <= 4'd0;
            key_code_reg <= 4'd0;
            press_reg    <= 1'b0;
            release_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            cand_reg     <= cand_next;
            key_code_reg <= key_code_next;
            press_reg    <= press_next;
            release_reg  <= release_next;
        end
    end

    assign key_code    = key_code_reg;
    assign key_press   = press_reg;
    assign key_release = release_reg;
    assign key_down    = (state_reg == ST_PRESSED) || (state_reg == ST_REL);

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Directed bench: a switch-matrix model closes keys against the driven rows,
// and pulse counters track press/release events for hand-computed checks.
module tb_keypad_scan_debounce;

    logic       hwclk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] keypad_r;
    logic [3:0] keypad_c;
    logic [3:0] key_code;
    logic       key_press;
    logic       key_release;
    logic       key_down;

    logic [15:0] keys = 16'h0000;   // index r*4+c, 1 = switch closed

    int checks    = 0;
    int failures  = 0;
    int press_cnt = 0;
    int rel_cnt   = 0;
    int both_cnt  = 0;

    keypad_scan_debounce #(
        .SETTLE_CYCLES (4),
        .DEBOUNCE_SCANS(3)
    ) dut (
        .hwclk      (hwclk),
        .rst_n      (rst_n),
        .keypad_r   (keypad_r),
        .keypad_c   (keypad_c),
        .key_code   (key_code),
        .key_press  (key_press),
        .key_release(key_release),
        .key_down   (key_down)
    );

    always #5 hwclk = ~hwclk;

    // A closed switch pulls its column low only while its row is driven low.
    always_comb begin
        keypad_c = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && (keypad_r[r] === 1'b0)) begin
                    keypad_c[c] = 1'b0;
                end
            end
        end
    end

    always @(posedge hwclk) begin
        if (key_press === 1'b1)                          press_cnt <= press_cnt + 1;
        if (key_release === 1'b1)                        rel_cnt   <= rel_cnt + 1;
        if (key_press === 1'b1 && key_release === 1'b1)  both_cnt  <= both_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("check %s ok (%0h)", tag, obs);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge hwclk);
        #1;
    endtask

    task automatic wait_press(input int start, input int limit, output int cyc);
        cyc = 0;
        while (press_cnt == start && cyc < limit) begin
            tick(1);
            cyc++;
        end
    endtask

    task automatic wait_rel(input int start, input int limit, output int cyc);
        cyc = 0;
        while (rel_cnt == start && cyc < limit) begin
            tick(1);
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        int p0;
        int r0;
        logic [3:0] exp_r;

        // 1. reset state, then row walk
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("rst_rows", 32'(keypad_r), 32'hF);
            check("rst_outs", {key_code, key_press, key_release, key_down}, 32'h0);
        end
        rst_n = 1'b1;
        tick(1);
        for (int k = 0; k < 8; k++) begin
            exp_r = ~(4'b0001 << (k % 4));
            check("row_walk", 32'(keypad_r), 32'(exp_r));
            tick(4);
        end

        // 2. clean press of r2/c1
        p0 = press_cnt;
        r0 = rel_cnt;
        keys[9] = 1'b1;
        wait_press(p0, 200, cyc);
        check("press_seen", 32'(press_cnt != p0), 32'h1);
        check("press_latency_ok", 32'(cyc >= 36 && cyc <= 76), 32'h1);
        tick(100);
        check("press_count", 32'(press_cnt - p0), 32'h1);
        check("press_code", 32'(key_code), 32'h9);
        check("press_down", 32'(key_down), 32'h1);
        check("press_no_rel", 32'(rel_cnt - r0), 32'h0);

        // 4. short reopen is absorbed, full release is accepted
        p0 = press_cnt;
        keys[9] = 1'b0;
        tick(20);
        keys[9] = 1'b1;
        tick(100);
        check("reopen_no_rel", 32'(rel_cnt - r0), 32'h0);
        check("reopen_no_press", 32'(press_cnt - p0), 32'h0);
        check("reopen_down", 32'(key_down), 32'h1);
        keys[9] = 1'b0;
        wait_rel(r0, 200, cyc);
        check("rel_seen", 32'(rel_cnt != r0), 32'h1);
        tick(20);
        check("rel_count", 32'(rel_cnt - r0), 32'h1);
        check("rel_down", 32'(key_down), 32'h0);
        check("rel_code_held", 32'(key_code), 32'h9);

        // 3. bounce then hold, and a single-scan closure
        p0 = press_cnt;
        for (int i = 0; i < 8; i++) begin
            keys[9] = ~keys[9];
            tick(5);
        end
        check("bounce_no_press", 32'(press_cnt - p0), 32'h0);
        keys[9] = 1'b1;
        wait_press(p0, 200, cyc);
        tick(100);
        check("bounce_press_once", 32'(press_cnt - p0), 32'h1);
        check("bounce_code", 32'(key_code), 32'h9);
        r0 = rel_cnt;
        keys[9] = 1'b0;
        wait_rel(r0, 200, cyc);
        tick(10);
        check("bounce_rel", 32'(rel_cnt - r0), 32'h1);
        p0 = press_cnt;
        r0 = rel_cnt;
        keys[9] = 1'b1;
        tick(10);
        keys[9] = 1'b0;
        tick(120);
        check("glitch_no_press", 32'(press_cnt - p0), 32'h0);
        check("glitch_no_rel", 32'(rel_cnt - r0), 32'h0);

        // 5. multi-key handling
        keys[0]  = 1'b1;
        keys[15] = 1'b1;
        tick(150);
        check("multi_no_press", 32'(press_cnt - p0), 32'h0);
        check("multi_not_down", 32'(key_down), 32'h0);
        keys = 16'h0000;
        tick(40);
        keys[0] = 1'b1;
        wait_press(p0, 200, cyc);
        tick(20);
        check("r0c0_code", 32'(key_code), 32'h0);
        keys[15] = 1'b1;
        tick(100);
        keys[15] = 1'b0;
        tick(100);
        check("owner_press_once", 32'(press_cnt - p0), 32'h1);
        check("owner_no_rel", 32'(rel_cnt - r0), 32'h0);
        check("owner_down", 32'(key_down), 32'h1);
        check("owner_code", 32'(key_code), 32'h0);
        keys = 16'h0000;
        wait_rel(r0, 200, cyc);
        tick(10);
        check("owner_rel", 32'(rel_cnt - r0), 32'h1);

        // 6. reset mid-CAND and mid-PRESSED
        p0 = press_cnt;
        r0 = rel_cnt;
        keys[9] = 1'b1;
        tick(25);
        rst_n = 1'b0;
        tick(1);
        check("cand_rst_rows", 32'(keypad_r), 32'hF);
        check("cand_rst_down", 32'(key_down), 32'h0);
        tick(1);
        check("cand_rst_no_press", 32'(press_cnt - p0), 32'h0);
        rst_n = 1'b1;
        wait_press(p0, 200, cyc);
        check("rededounce_latency_ok", 32'(cyc >= 36 && cyc <= 76), 32'h1);
        check("rededounce_code", 32'(key_code), 32'h9);
        tick(30);
        p0 = press_cnt;
        rst_n = 1'b0;
        tick(1);
        check("prs_rst_outs", {key_code, key_press, key_release, key_down}, 32'h0);
        check("prs_rst_rows", 32'(keypad_r), 32'hF);
        tick(2);
        check("prs_rst_no_events", 32'((press_cnt - p0) + (rel_cnt - r0)), 32'h0);
        rst_n = 1'b1;
        wait_press(p0, 200, cyc);
        tick(5);
        check("prs_repress_code", 32'(key_code), 32'h9);
        check("prs_repress_down", 32'(key_down), 32'h1);
        keys = 16'h0000;
        tick(80);

        check("never_both", 32'(both_cnt), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
